stopwatch_core: RTL and testbench

STOPWATCH_CORE -- requirements
Module: stopwatch_core

---
 rtl/stopwatch_core_if.sv | 25 ++
 rtl/stopwatch_core.sv | 116 +++++++++++
 tb/tb_stopwatch_core.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/stopwatch_core_if.sv
// Stopwatch control/display bundle: divided-clock and button levels in,
// BCD MM:SS digits and mode flags out.
interface stopwatch_core_if;
    logic       clk1;
    logic       clk2;
    logic       pause;
    logic       adj;
    logic       sel;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       running;
    logic       adj_min;
    logic       adj_sec;

    modport slave (
        input  clk1, clk2, pause, adj, sel,
        output min_tens, min_ones, sec_tens, sec_ones, running, adj_min, adj_sec
    );
    modport master (
        output clk1, clk2, pause, adj, sel,
        input  min_tens, min_ones, sec_tens, sec_ones, running, adj_min, adj_sec
    );
endinterface

// File: rtl/stopwatch_core.sv
// MM:SS stopwatch with PAUSED/RUN/ADJUST modes; all slow inputs are
// synchronized and treated as data in the single clk domain.
module stopwatch_core #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_MIN     = 59
) (
    input  logic            clk,
    input  logic            reset,
    stopwatch_core_if.slave sw
);
    typedef enum logic [1:0] {PAUSED, RUN, ADJUST} state_e;

    localparam int         NIN   = 5;
    localparam logic [7:0] MAX_B = 8'(MAX_MIN);

    logic [SYNC_STAGES-1:0][NIN-1:0] sync_q;
    logic [NIN-1:0] raw, syn;
    logic [2:0]     hist_q, pulse;
    logic           tick1, tick2, pause_p, adj_s, sel_s;

    state_e     state_q, state_d;
    logic [7:0] sec_q, sec_d, min_q, min_d;
    logic       running_q, adj_min_q, adj_sec_q;

    assign raw = {sw.sel, sw.adj, sw.pause, sw.clk2, sw.clk1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= raw;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            hist_q <= syn[2:0];
        end
    end

    assign syn     = sync_q[SYNC_STAGES-1];
    assign pulse   = syn[2:0] & ~hist_q;
    assign tick1   = pulse[0];
    assign tick2   = pulse[1];
    assign pause_p = pulse[2];
    assign adj_s   = syn[3];
    assign sel_s   = syn[4];

    function automatic logic [7:0] bcd_inc(input logic [7:0] b);
        if (b[3:0] == 4'd9) return {b[7:4] + 4'd1, 4'h0};
        return {b[7:4], b[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] sec_inc(input logic [7:0] s);
        if (s == 8'h59) return 8'h00;
        return bcd_inc(s);
    endfunction

    // Minutes wrap is compared in binary so any MAX_MIN in 1..99 works.
    function automatic logic [7:0] min_inc(input logic [7:0] m);
        if (({4'b0, m[7:4]} * 8'd10 + {4'b0, m[3:0]}) == MAX_B) return 8'h00;
        return bcd_inc(m);
    endfunction

    always_comb begin
        state_d = state_q;
        sec_d   = sec_q;
        min_d   = min_q;
        case (state_q)
            PAUSED: begin
                if (adj_s)        state_d = ADJUST;
                else if (pause_p) state_d = RUN;
            end
            RUN: begin
                if (tick1) begin
                    sec_d = sec_inc(sec_q);
                    if (sec_q == 8'h59) min_d = min_inc(min_q);
                end
                if (adj_s)        state_d = ADJUST;
                else if (pause_p) state_d = PAUSED;
            end
            ADJUST: begin
                if (tick2) begin
                    if (sel_s) sec_d = sec_inc(sec_q);
                    else       min_d = min_inc(min_q);
                end
                if (!adj_s) state_d = PAUSED;
            end
            default: state_d = PAUSED;
        endcase
    end

    // Flags decode the next state so they line up with the state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= PAUSED;
            sec_q     <= '0;
            min_q     <= '0;
            running_q <= 1'b0;
            adj_min_q <= 1'b0;
            adj_sec_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sec_q     <= sec_d;
            min_q     <= min_d;
            running_q <= (state_d == RUN);
            adj_min_q <= (state_d == ADJUST) && !sel_s;
            adj_sec_q <= (state_d == ADJUST) && sel_s;
        end
    end

    assign sw.min_tens = min_q[7:4];
    assign sw.min_ones = min_q[3:0];
    assign sw.sec_tens = sec_q[7:4];
    assign sw.sec_ones = sec_q[3:0];
    assign sw.running  = running_q;
    assign sw.adj_min  = adj_min_q;
    assign sw.adj_sec  = adj_sec_q;
endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core: a seconds-total model checked every
// cycle, plus literal display checks at key points.
module tb_stopwatch_core;
    localparam int S    = 2;
    localparam int MAXM = 59;
    localparam int PA = 0, RU = 1, AD = 2;
    localparam int C1 = 0, C2 = 1, PS = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    stopwatch_core_if sw();

    stopwatch_core #(.SYNC_STAGES(S), .MAX_MIN(MAXM)) dut (
        .clk   (clk),
        .reset (reset),
        .sw    (sw)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] disp();
        return {sw.min_tens, sw.min_ones, sw.sec_tens, sw.sec_ones};
    endfunction

    // Model: inputs seen at edge k act at edge k+S as single edge pulses.
    logic [4:0] samp [0:S];
    int  m_st = PA, m_min = 0, m_sec = 0;
    bit  m_sel = 0;

    initial begin
        bit c1p, c2p, pp, adjs;
        int t;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                for (int i = 0; i <= S; i++) samp[i] = '0;
                m_st = PA; m_min = 0; m_sec = 0; m_sel = 0;
            end else begin
                c1p   = samp[S-1][0] && !samp[S][0];
                c2p   = samp[S-1][1] && !samp[S][1];
                pp    = samp[S-1][2] && !samp[S][2];
                adjs  = samp[S-1][3];
                m_sel = samp[S-1][4];
                if (m_st == RU && c1p) begin
                    t = (m_min * 60 + m_sec + 1) % ((MAXM + 1) * 60);
                    m_min = t / 60;
                    m_sec = t % 60;
                end else if (m_st == AD && c2p) begin
                    if (m_sel) m_sec = (m_sec + 1) % 60;
                    else       m_min = (m_min + 1) % (MAXM + 1);
                end
                if (m_st != AD && adjs)       m_st = AD;
                else if (m_st == AD && !adjs) m_st = PA;
                else if (m_st != AD && pp)    m_st = (m_st == RU) ? PA : RU;
                for (int i = S; i > 0; i--) samp[i] = samp[i-1];
                samp[0] = {sw.sel, sw.adj, sw.pause, sw.clk2, sw.clk1};
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("m_sec_ones", sw.sec_ones, m_sec % 10);
                check("m_sec_tens", sw.sec_tens, m_sec / 10);
                check("m_min_ones", sw.min_ones, m_min % 10);
                check("m_min_tens", sw.min_tens, m_min / 10);
                check("m_running",  sw.running, m_st == RU);
                check("m_adj_min",  sw.adj_min, m_st == AD && !m_sel);
                check("m_adj_sec",  sw.adj_sec, m_st == AD && m_sel);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int which, input logic v);
        case (which)
            C1:      sw.clk1  = v;
            C2:      sw.clk2  = v;
            default: sw.pause = v;
        endcase
    endtask

    task automatic pulse(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            drive(which, 1'b1); cyc(3);
            drive(which, 1'b0); cyc(3);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; cyc(2);
        reset = 1'b0; cyc(2);
    endtask

    task automatic preload(input int mm, input int ss);
        sw.adj = 1'b1; sw.sel = 1'b0; cyc(4);
        pulse(C2, mm);
        sw.sel = 1'b1; cyc(4);
        pulse(C2, ss);
        sw.adj = 1'b0; cyc(4);
    endtask

    initial begin
        int lat;
        sw.clk1 = 0; sw.clk2 = 0; sw.pause = 0; sw.adj = 0; sw.sel = 0;
        cyc(3);
        check("rst_disp", disp(), 16'h0000);
        check("rst_running", sw.running, 0);
        check("rst_adj", {sw.adj_min, sw.adj_sec}, 0);
        reset = 1'b0; cyc(2);

        pulse(PS, 1);
        pulse(C1, 5);
        check("run5_disp", disp(), 16'h0005);
        check("run5_running", sw.running, 1);

        preload(59, 54);
        check("pre5959", disp(), 16'h5959);
        pulse(PS, 1);
        pulse(C1, 1);
        check("wrap_full", disp(), 16'h0000);
        preload(9, 59);
        pulse(PS, 1);
        pulse(C1, 1);
        check("carry_min", disp(), 16'h1000);

        do_reset();
        sw.adj = 1'b1; sw.sel = 1'b1; cyc(4);
        pulse(C2, 61);
        check("adj61_disp", disp(), 16'h0001);
        check("adj61_adj_sec", sw.adj_sec, 1);
        check("adj61_adj_min", sw.adj_min, 0);
        pulse(C1, 2);
        check("adj_c1_ignored", disp(), 16'h0001);

        sw.adj = 1'b0; cyc(4);
        pulse(PS, 1);
        pulse(C1, 2);
        sw.pause = 1'b1; sw.clk1 = 1'b1; cyc(4);
        check("sim_pause_disp", disp(), 16'h0004);
        check("sim_pause_run", sw.running, 0);
        sw.pause = 1'b0; sw.clk1 = 1'b0; cyc(3);
        pulse(C1, 2);
        check("paused_hold", disp(), 16'h0004);

        pulse(PS, 1);
        sw.adj = 1'b1; sw.clk1 = 1'b1; cyc(4);
        check("sim_adj_disp", disp(), 16'h0005);
        check("sim_adj_flag", sw.adj_sec, 1);
        sw.adj = 1'b0; sw.clk1 = 1'b0; cyc(4);

        do_reset();
        preload(12, 34);
        pulse(PS, 1);
        check("pre1234", disp(), 16'h1234);
        @(negedge clk); #2 reset = 1'b1;
        #1;
        check("async_rst_disp", disp(), 16'h0000);
        check("async_rst_run", sw.running, 0);
        #1 reset = 1'b0;
        cyc(3);

        sw.pause = 1'b1; cyc(20);
        check("held_pause", sw.running, 1);
        sw.pause = 1'b0; cyc(4);
        @(posedge clk); #9 sw.clk1 = 1'b1;
        lat = 0;
        for (int n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (lat == 0 && sw.sec_ones != 4'd0) lat = n;
        end
        check("latency", lat, S + 1);
        sw.clk1 = 1'b0; cyc(4);
        check("latency_disp", disp(), 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
